mux_select_arbiter: RTL and testbench
=====================================

// Module: mux_select_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 4:1-muxed resource (e.g. a shared memory or
//  register-file write port) among four requesters. Grants one requester at a time
//  and drives the 2-bit select of the downstream Mux4 from a registered owner index.
//  Sits between the requesting units and the shared Mux4; the only sequential logic
//  on that path. A grant is bounded by a hold limit so that no requester starves.
// PARAMETERS
//  MAX_HOLD    8   max consecutive cycles one owner may hold the grant (>=1)
//  HOLD_W      4   width of hold counter; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//  clk       in   1  single clock; all state updates on rising edge
//  rst_n     in   1  synchronous reset, active-low
//  req       in   4  request per requester; held high while access wanted
//  done      in   4  release pulse per requester; only the owner's bit is honoured
//  grant     out  4  one-hot grant, or 0 when idle; registered
//  select    out  2  owner index driving Mux4 select; registered
//  busy      out  1  high while a grant is active (state GRANT)
//  timeout   out  1  one-cycle pulse: previous grant ended by hold limit
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, grant=0, select=0, busy=0, timeout=0,
//   ptr=0, hold_cnt=0. Applies mid-grant too; the grant is dropped at that edge.
//  ptr = index searched first; after each win, ptr = (winner+1) mod 4.
//  Pick rule: first set bit of the candidate vector scanning ptr, ptr+1, .. mod 4.
//  IDLE: if |req, pick over req -> next edge: GRANT, grant=onehot(w), select=w,
//   hold_cnt=0, ptr=w+1. Latency req->grant = 1 cycle. If req=0, stay IDLE;
//   select keeps its last value.
//  GRANT (owner o): release when any of the following holds this cycle:
//   done[o]=1, req[o]=0, or hold_cnt==MAX_HOLD-1. Otherwise hold_cnt++ and all
//   outputs hold.
//  On release: pick over req & ~onehot(o) (owner excluded this round).
//   Winner w exists -> GRANT w next edge (back-to-back, no idle bubble),
//   hold_cnt=0. No winner -> IDLE next edge, grant=0.
//  timeout=1 for the single cycle after a release caused only by the hold limit
//   (done[o]=0 and req[o]=1); 0 otherwise.
//  done and req[o] drop in the same cycle -> one release; no double advance.
//  done on a non-owner bit, or done while IDLE -> ignored.
//  A requester dropping req before it is granted -> never granted; no side effect.
//  MAX_HOLD=1 -> every grant lasts exactly one cycle and rotates under contention.
//  grant is always one-hot or zero. select equals the grant index whenever busy=1.
//  hold_cnt never exceeds MAX_HOLD-1; no wrap.
// STRUCTURE
//  Shared package/header: state encoding (IDLE=1'b0, GRANT=1'b1), NUM_REQ=4,
//   SEL_W=2.
//  One sub-module: rr_pick4 -- combinational; inputs cand[3:0] and ptr[1:0];
//   outputs found and idx[1:0]. Rotate, priority-encode, rotate back.
//  Top level: state register, owner/ptr/hold_cnt registers, release logic, and
//   output registers.
// TESTING
//  1 Reset: rst_n=0 for 2 edges with req=4'hF -> grant=0, select=0, busy=0,
//    timeout=0.
//  2 Single: req=4'b0100 from IDLE -> next cycle grant=0100, select=2, busy=1;
//    done[2] pulse -> next cycle grant=0, busy=0, select stays 2.
//  3 Rotation: req=4'hF held, each owner pulses done the cycle after its grant
//    -> grants in order 0001,0010,0100,1000,0001 with no idle cycle between them.
//  4 Hold limit: MAX_HOLD=8, req=4'b0011 held, no done -> owner 0 held 8 cycles;
//    then grant=0010 and timeout=1 for 1 cycle.
//  5 Edge events: owner 1 drops req[1] in the same cycle done[1]=1 -> a single
//    handover; done[3] while the owner is 1 -> no change.
//  6 Mid-op reset: rst_n=0 during a GRANT with hold_cnt=5 -> next edge all
//    outputs at reset values; after rst_n=1 with req=4'b1000 -> grant=1000 one
//    cycle later (ptr restarted at 0).

Source files
------------

// File: rtl/mux_select_arbiter_pkg.sv
// Shared definitions for the round-robin Mux4 select arbiter: state encoding,
// requester count and select width, plus a one-hot helper.
package mux_select_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set bit of cand scanning from ptr upward,
// wrapping modulo four.
module rr_pick4
  import mux_select_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [SEL_W-1:0]     offset;

  // Rotate so that bit 0 is the ptr position, priority-encode, then rotate back.
  always_comb begin
    doubled = {cand, cand};
    rotated = NUM_REQ'(doubled >> ptr);
    offset  = 2'd0;
    if (rotated[0])      offset = 2'd0;
    else if (rotated[1]) offset = 2'd1;
    else if (rotated[2]) offset = 2'd2;
    else if (rotated[3]) offset = 2'd3;
    found = |cand;
    idx   = ptr + offset;
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter for a shared 4:1-muxed resource; drives the registered one-hot
// grant and the Mux4 select, bounding each grant by MAX_HOLD cycles.
module mux_select_arbiter
  import mux_select_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               busy,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arbState_e          state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] candidate;
  logic               pickFound;
  logic [SEL_W-1:0]   pickIdx;
  logic               ownerDone;
  logic               ownerReq;
  logic               holdExpired;
  logic               releaseGrant;

  // select_q doubles as the owner index while a grant is active.
  assign ownerDone    = done[select_q];
  assign ownerReq     = req[select_q];
  assign holdExpired  = (holdCnt_q == HOLD_LAST);
  assign releaseGrant = ownerDone | ~ownerReq | holdExpired;
  assign candidate    = (state_q == GRANT) ? (req & ~onehot4(select_q)) : req;

  rr_pick4 uPick (
    .cand  (candidate),
    .ptr   (ptr_q),
    .found (pickFound),
    .idx   (pickIdx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    grant_d   = grant_q;
    select_d  = select_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d   = GRANT;
          grant_d   = onehot4(pickIdx);
          select_d  = pickIdx;
          holdCnt_d = '0;
          ptr_d     = pickIdx + 2'd1;
        end
      end
      GRANT: begin
        if (releaseGrant) begin
          timeout_d = holdExpired & ~ownerDone & ownerReq;
          holdCnt_d = '0;
          if (pickFound) begin
            grant_d  = onehot4(pickIdx);
            select_d = pickIdx;
            ptr_d    = pickIdx + 2'd1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      holdCnt_q <= '0;
      grant_q   <= '0;
      select_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      grant_q   <= grant_d;
      select_q  <= select_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign select  = select_q;
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Self-checking bench: directed vectors with literal expectations plus a per-cycle
// comparison against a behavioural round-robin model.
module tb_mux_select_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  mux_select_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .select  (select),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer owner/pointer/hold bookkeeping updated per edge.
  bit modelValid = 1'b0;
  bit mBusy;
  int mOwner, mPtr, mHold, mSelect;
  bit mTimeout;

  function automatic int pickModel(input logic [3:0] c, input int p);
    for (int k = 0; k < 4; k++) begin
      if (c[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    bit byDone, wanted, limit;
    if (!rst_n) begin
      mBusy = 0; mOwner = 0; mPtr = 0; mHold = 0; mSelect = 0; mTimeout = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      mTimeout = 0;
      if (!mBusy) begin
        w = pickModel(req, mPtr);
        if (w >= 0) begin
          mBusy = 1; mOwner = w; mSelect = w; mHold = 0; mPtr = (w + 1) % 4;
        end
      end else begin
        byDone = done[mOwner];
        wanted = req[mOwner];
        limit  = (mHold == MAX_HOLD - 1);
        if (byDone || !wanted || limit) begin
          mTimeout = !byDone && wanted;
          w = pickModel(req & ~(4'b0001 << mOwner), mPtr);
          mHold = 0;
          if (w >= 0) begin
            mOwner = w; mSelect = w; mPtr = (w + 1) % 4;
          end else begin
            mBusy = 0;
          end
        end else begin
          mHold++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] expGrant;
    if (modelValid) begin
      expGrant = mBusy ? (4'b0001 << mOwner) : 4'b0000;
      checks++;
      if (grant !== expGrant || select !== 2'(mSelect) || busy !== mBusy ||
          timeout !== mTimeout) begin
        errors++;
        $display("[TB] FAIL model_cycle t=%0t got grant=%b select=%0d busy=%b timeout=%b required grant=%b select=%0d busy=%b timeout=%b",
                 $time, grant, select, busy, timeout, expGrant, mSelect, mBusy, mTimeout);
      end
    end
  end

  task automatic applyStimulus(input logic rstn, input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    rst_n = rstn;
    req   = r;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic [1:0] s,
                             input logic b, input logic t);
    checks++;
    if (grant !== g || select !== s || busy !== b || timeout !== t) begin
      errors++;
      $display("[TB] FAIL %s got grant=%b select=%0d busy=%b timeout=%b required grant=%b select=%0d busy=%b timeout=%b",
               name, grant, select, busy, timeout, g, s, b, t);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'h0;
    done  = 4'h0;

    // Reset held two edges with every requester asking.
    applyStimulus(1'b0, 4'hF, 4'h0);
    applyStimulus(1'b0, 4'hF, 4'h0);
    checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester, release by done, select retained while idle.
    applyStimulus(1'b1, 4'b0100, 4'h0);
    checkOutput("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    checkOutput("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0100);
    checkOutput("idle_done_ignored", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Rotation under full contention, starting from a fresh pointer.
    applyStimulus(1'b0, 4'h0, 4'h0);
    applyStimulus(1'b1, 4'hF, 4'h0);
    checkOutput("rot_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hF, 4'b0001);
    checkOutput("rot_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hF, 4'b0010);
    checkOutput("rot_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hF, 4'b0100);
    checkOutput("rot_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hF, 4'b1000);
    checkOutput("rot_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Hold limit: owner 0 keeps the grant for MAX_HOLD cycles, then timeout.
    applyStimulus(1'b0, 4'h0, 4'h0);
    applyStimulus(1'b1, 4'b0011, 4'h0);
    checkOutput("hold_start", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      applyStimulus(1'b1, 4'b0011, 4'h0);
      checkOutput($sformatf("hold_cycle_%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 4'b0011, 4'h0);
    checkOutput("hold_timeout", 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0011, 4'h0);
    checkOutput("timeout_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Owner drops req and pulses done together: exactly one handover.
    applyStimulus(1'b1, 4'b0001, 4'b0010);
    checkOutput("joint_release", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'b0001);
    checkOutput("back_to_owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'b1000);
    checkOutput("nonowner_done", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Reset mid-grant once the hold counter reaches 5.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0011, 4'h0);
    checkOutput("pre_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b1000, 4'h0);
    checkOutput("midop_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 4'h0);
    checkOutput("after_reset_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'h0);
    checkOutput("final_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
